apb_master_if: RTL and testbench
================================

Name: apb_master_if

Overview:
APB requester (master) that turns single-transfer commands from a local client into compliant two-phase APB transfers (SETUP, then ACCESS) towards an APB completer such as the team's memory-backed APB slave. It waits on pready, returns read data or write completion to the client, and aborts a transfer with an error flag when the completer stalls for too long. One transfer is outstanding at a time.

Parameters:
ADDR_WIDTH, 2, width of paddr and cmd_addr
DATA_WIDTH, 4, width of pwdata, prdata, cmd_wdata and rsp_rdata
TIMEOUT_CYCLES, 16, ACCESS cycles with pready=0 tolerated before abort; 0 disables the timeout

Ports:
pclk  in  1  clock; all logic on the rising edge
prst  in  1  reset; one clock, reset is synchronous and active-low
cmd_valid  in  1  client presents a transfer
cmd_ready  out  1  block can accept a command (combinational: state==IDLE)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
rsp_err  out  1  qualified by rsp_valid; 1 = aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data

Behaviour:
- Reset (prst=0 at a rising edge): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and the wait counter all 0. Applies mid-transfer: the in-flight transfer is dropped, no rsp_valid is issued, and psel falls at that edge.
- States: IDLE, SETUP, ACCESS (encoding in package).
- IDLE: cmd_ready=1; psel=penable=0; pwrite, paddr and pwdata are driven to 0. On cmd_valid=1, the command is captured at the edge and the state moves to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, and paddr, pwrite and pwdata take the captured values. pwdata=0 for reads. The state moves to ACCESS unconditionally.
- ACCESS: psel=1, penable=1; paddr, pwrite and pwdata are held unchanged.
  - pready=1 at an edge: the transfer completes. Next cycle: state IDLE, rsp_valid=1, rsp_err=0, and rsp_rdata = prdata sampled at that edge for reads, 0 for writes.
  - pready=0: the wait counter increments. If the counter equals TIMEOUT_CYCLES-1 at that edge and TIMEOUT_CYCLES!=0, the transfer aborts. Next cycle: IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The wait counter clears on entry to SETUP. The counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- rsp_valid is high for exactly one cycle; there is no backpressure on the response. rsp_rdata and rsp_err hold until the next response.
- Throughput: the minimum is 3 cycles per transfer, accept edge to next accept edge (IDLE, SETUP, ACCESS). cmd_valid held high gives back-to-back transfers at that rate. A command can be accepted in the same cycle that rsp_valid is high.
- A cmd_valid that is not in IDLE is ignored; the client must hold it until cmd_ready.
- pready and prdata are ignored outside ACCESS.
- With TIMEOUT_CYCLES=1, the abort happens on the first ACCESS cycle that has pready=0.

Decomposition:
- Shared package apb_pkg: state typedef (IDLE/SETUP/ACCESS) and default ADDR_WIDTH/DATA_WIDTH constants, also used by the APB slave and benches.
- One natural sub-module: apb_wait_timer, a parameterised counter with clear, enable and expired outputs, used for the timeout.

Test Plan:
- Single write, pready tied 1: cmd at addr 1, wdata 0xA accepted at T0. Expect psel=1/penable=0 at T0+1, penable=1 at T0+2, rsp_valid=1 with rsp_err=0 at T0+3, and paddr=1/pwdata=0xA stable across both phases.
- Read with 3 wait states: pready=0 for 3 ACCESS cycles, then 1 with prdata=0x5. Expect penable high for 4 cycles, then rsp_valid=1 with rsp_rdata=0x5.
- Back-to-back: cmd_valid held with writes to addr 0..3, then reads of 0..3 against the APB slave. Expect an accept every 3 cycles and read data matching the written data.
- Timeout: TIMEOUT_CYCLES=4, pready held 0. Expect 4 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, and cmd_ready=1 the same cycle.
- Reset mid-ACCESS: prst=0 for one edge during a read wait state. Expect all outputs 0 next cycle, no rsp_valid, and a following write of 0x3 to addr 2 completing normally.
- Ignored stimulus: pready pulsed in IDLE/SETUP and cmd_valid toggled during ACCESS. Expect no early completion and no extra accept.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer phase encoding, default bus widths and
// the sizing rule for the wait-state timer.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 2;
    localparam int APB_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter: cleared at the start of a transfer, counts stalled
// cycles, and flags the last tolerated cycle. LIMIT of 0 never expires.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = timer_width(LIMIT);
    localparam logic [CW-1:0] LAST = (LIMIT == 0) ? {CW{1'b0}} : CW'(LIMIT - 1);

    logic [CW-1:0] count_r;

    // Stall counter; rst is active-low and synchronous, clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en) begin
            count_r <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (LIMIT != 0) && (count_r == LAST);

endmodule

// File: rtl/apb_master_if.sv
// APB requester: turns single client commands into SETUP/ACCESS transfers,
// returns read data or completion, and aborts long stalls with rsp_err.
module apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    apb_state_e            state_r;
    apb_state_e            state_s;
    logic                  psel_s;
    logic                  penable_s;
    logic                  pwrite_s;
    logic [ADDR_WIDTH-1:0] paddr_s;
    logic [DATA_WIDTH-1:0] pwdata_s;
    logic                  rsp_valid_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_s;
    logic                  rsp_err_s;
    logic                  tmr_clr_s;
    logic                  tmr_en_s;
    logic                  tmr_expired_s;

    apb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (pclk),
        .rst    (prst),
        .clr    (tmr_clr_s),
        .en     (tmr_en_s),
        .expired(tmr_expired_s)
    );

    assign cmd_ready = (state_r == IDLE);

    // Next state and next bus/response values; the bus is zeroed whenever idle.
    always_comb begin
        state_s     = state_r;
        psel_s      = psel;
        penable_s   = penable;
        pwrite_s    = pwrite;
        paddr_s     = paddr;
        pwdata_s    = pwdata;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata;
        rsp_err_s   = rsp_err;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
                pwrite_s  = 1'b0;
                paddr_s   = ADDR_ZERO;
                pwdata_s  = DATA_ZERO;
                if (cmd_valid) begin
                    state_s   = SETUP;
                    psel_s    = 1'b1;
                    pwrite_s  = cmd_write;
                    paddr_s   = cmd_addr;
                    pwdata_s  = cmd_write ? cmd_wdata : DATA_ZERO;
                    tmr_clr_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s   = ACCESS;
                penable_s = 1'b1;
            end
            ACCESS: begin
                if (pready || tmr_expired_s) begin
                    state_s     = IDLE;
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    pwrite_s    = 1'b0;
                    paddr_s     = ADDR_ZERO;
                    pwdata_s    = DATA_ZERO;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = !pready;
                    rsp_rdata_s = (pready && !pwrite) ? prdata : DATA_ZERO;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
                pwrite_s  = 1'b0;
                paddr_s   = ADDR_ZERO;
                pwdata_s  = DATA_ZERO;
            end
        endcase
    end

    // State and registered outputs; prst drops any in-flight transfer silently.
    always_ff @(posedge pclk) begin
        if (!prst) begin
            state_r   <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= ADDR_ZERO;
            pwdata    <= DATA_ZERO;
            rsp_valid <= 1'b0;
            rsp_rdata <= DATA_ZERO;
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_s;
            psel      <= psel_s;
            penable   <= penable_s;
            pwrite    <= pwrite_s;
            paddr     <= paddr_s;
            pwdata    <= pwdata_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_err   <= rsp_err_s;
        end
    end

endmodule

// File: tb/tb_apb_master_if.sv
// Bench for apb_master_if: transfer-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_apb_master_if;
    import apb_pkg::*;

    localparam int AW = 2;
    localparam int DW = 4;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          prst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;

    always #5 pclk = ~pclk;

    apb_master_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transfer-level model: m_k counts cycles since accept (1 = setup, >=2 = access).
    bit            m_ok = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_accepted = 1'b0;
    int            m_k = 0;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] mem [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    int            cycle = 0;

    logic          e_cmd_ready = 1'b1, e_psel = 1'b0, e_penable = 1'b0, e_pwrite = 1'b0;
    logic [AW-1:0] e_paddr = '0;
    logic [DW-1:0] e_pwdata = '0;
    logic          e_rsp_valid = 1'b0, e_rsp_err = 1'b0;
    logic [DW-1:0] e_rsp_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge.
    task automatic step();
        @(posedge pclk);
        cycle++;
        m_accepted = 1'b0;
        if (!prst) begin
            m_ok = 1'b1;
            m_busy = 1'b0;
            e_rsp_valid = 1'b0;
            e_rsp_err = 1'b0;
            e_rsp_rdata = '0;
        end else if (m_ok) begin
            e_rsp_valid = 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1'b1;
                    m_k = 1;
                    m_write = cmd_write;
                    m_addr = cmd_addr;
                    m_wdata = cmd_write ? cmd_wdata : '0;
                    m_accepted = 1'b1;
                end
            end else if (m_k == 1) begin
                m_k = 2;
            end else if (pready) begin
                m_busy = 1'b0;
                e_rsp_valid = 1'b1;
                e_rsp_err = 1'b0;
                e_rsp_rdata = m_write ? '0 : prdata;
                if (m_write) mem[m_addr] = m_wdata;
            end else if (m_k - 2 == TO - 1) begin
                m_busy = 1'b0;
                e_rsp_valid = 1'b1;
                e_rsp_err = 1'b1;
                e_rsp_rdata = '0;
            end else begin
                m_k++;
            end
        end
        e_cmd_ready = !m_busy;
        e_psel      = m_busy;
        e_penable   = m_busy && (m_k >= 2);
        e_pwrite    = m_busy && m_write;
        e_paddr     = m_busy ? m_addr : '0;
        e_pwdata    = m_busy ? m_wdata : '0;
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge pclk) begin
        if (m_ok) begin
            check("cmd_ready", cmd_ready, e_cmd_ready);
            check("psel", psel, e_psel);
            check("penable", penable, e_penable);
            check("pwrite", pwrite, e_pwrite);
            check("paddr", paddr, e_paddr);
            check("pwdata", pwdata, e_pwdata);
            check("rsp_valid", rsp_valid, e_rsp_valid);
            check("rsp_rdata", rsp_rdata, e_rsp_rdata);
            check("rsp_err", rsp_err, e_rsp_err);
        end
    end

    initial begin
        int pen;
        int prev_acc;
        int idx;
        int resp_cnt;
        logic [DW-1:0] wtab [4];

        // Reset
        prst = 1'b0;
        step(); step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        prst = 1'b1;
        step();

        // Single write, pready tied high
        pready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 4'hA;
        step();
        cmd_valid = 1'b0;
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_paddr", paddr, 1);
        check("wr_setup_pwdata", pwdata, 4'hA);
        step();
        check("wr_access_penable", penable, 1);
        check("wr_access_paddr", paddr, 1);
        check("wr_access_pwdata", pwdata, 4'hA);
        step();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_psel_low", psel, 0);
        step();

        // Read with three wait states
        pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
        step();
        cmd_valid = 1'b0;
        step();
        pen = 0;
        for (int i = 0; i < 4; i++) begin
            if (penable) pen++;
            pready = (i == 3);
            prdata = (i == 3) ? 4'h5 : DW'($urandom);
            step();
        end
        pready = 1'b0;
        check("rd_penable_cycles", pen, 4);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 4'h5);
        step();

        // Back-to-back writes then reads, completer backed by mem
        for (int i = 0; i < 4; i++) wtab[i] = DW'(i * 5 + 3);
        pready = 1'b1;
        idx = 0; prev_acc = -1; resp_cnt = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = wtab[0];
        for (int c = 0; c < 60 && resp_cnt < 8; c++) begin
            prdata = m_busy ? mem[m_addr] : '0;
            step();
            if (m_accepted) begin
                if (prev_acc >= 0) check("b2b_spacing", cycle - prev_acc, 3);
                prev_acc = cycle;
                idx++;
                if (idx < 8) begin
                    cmd_write = (idx < 4);
                    cmd_addr  = AW'(idx % 4);
                    cmd_wdata = (idx < 4) ? wtab[idx] : DW'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_valid === 1'b1) begin
                if (resp_cnt >= 4) check("b2b_rdata", rsp_rdata, wtab[resp_cnt - 4]);
                resp_cnt++;
            end
        end
        check("b2b_responses", resp_cnt, 8);
        cmd_valid = 1'b0;
        step();

        // Timeout with pready held low
        pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3;
        step();
        cmd_valid = 1'b0;
        pen = 0;
        for (int i = 0; i < 20; i++) begin
            prdata = DW'($urandom);
            step();
            if (rsp_valid === 1'b1) break;
            if (penable === 1'b1) pen++;
        end
        check("to_penable_cycles", pen, 4);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel", psel, 0);
        check("to_cmd_ready", cmd_ready, 1);
        step();

        // Reset during a read wait state
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        prst = 1'b0;
        step();
        prst = 1'b1;
        check("mrst_psel", psel, 0);
        check("mrst_penable", penable, 0);
        check("mrst_paddr", paddr, 0);
        check("mrst_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 4'h3;
        step();
        cmd_valid = 1'b0;
        check("mrst_wr_pwdata", pwdata, 4'h3);
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid === 1'b1) break;
        end
        check("mrst_wr_rsp_valid", rsp_valid, 1);
        check("mrst_wr_rsp_err", rsp_err, 0);
        step();

        // Ignored stimulus: pready outside ACCESS, cmd_valid during ACCESS
        pready = 1'b1;
        step(); step();
        check("ign_idle_psel", psel, 0);
        check("ign_idle_rsp_valid", rsp_valid, 0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 4'h9;
        step();
        cmd_valid = 1'b0;
        step();
        check("ign_setup_no_rsp", rsp_valid, 0);
        check("ign_access_penable", penable, 1);
        pready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid = ~cmd_valid; cmd_addr = 2'd0; cmd_wdata = 4'h6;
            step();
            check("ign_toggle_paddr", paddr, 3);
        end
        cmd_valid = 1'b0; pready = 1'b1;
        step();
        check("ign_rsp_valid", rsp_valid, 1);
        step();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            prst      = ($urandom_range(0, 99) != 0);
            cmd_valid = $urandom_range(0, 1) == 1;
            cmd_write = $urandom_range(0, 1) == 1;
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            pready    = ($urandom_range(0, 2) == 0);
            prdata    = DW'($urandom);
            step();
        end

        @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
